// File: rtl/wdb_entry_alloc.sv
// Write-data-buffer entry allocator.
// Keeps the WDB free pool as a bitmap, pre-fetches one free index per channel
// into a registered slot, hands it out on alloc_vld&&alloc_rdy and takes
// entries back on rel_vld. At most one slot is refilled per cycle, chosen
// round-robin among slots that are empty or handshaking this cycle.
// Optional checking: define WDB_ALLOC_CHK_EN to enable the sticky alloc_err
// flag (double release, same-cycle duplicate release, release of a slot-held
// index). Without it alloc_err is tied low.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   alloc_vld/alloc_idx   per-channel slot valid and held index
//   alloc_rdy             per-channel consumer accept
//   rel_vld/rel_idx       per-channel release request and index
//   free_cnt              entries set in the free bitmap (slots excluded)
//   alloc_err             sticky illegal-release flag
module wdb_entry_alloc #(
    parameter int unsigned CH_NUM       = 4,
    parameter int unsigned DB_ENTRY_NUM = 64,
    parameter int unsigned IDX_W        = $clog2(DB_ENTRY_NUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [CH_NUM-1:0]    alloc_vld,
    output logic [IDX_W-1:0]     alloc_idx [CH_NUM-1:0],
    input  logic [CH_NUM-1:0]    alloc_rdy,
    input  logic [CH_NUM-1:0]    rel_vld,
    input  logic [IDX_W-1:0]     rel_idx   [CH_NUM-1:0],
    output logic [IDX_W:0]       free_cnt,
    output logic                 alloc_err
);

    localparam int unsigned PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [DB_ENTRY_NUM-1:0] free_vec;
    logic [CH_NUM-1:0]       slot_vld;
    logic [IDX_W-1:0]        slot_idx [CH_NUM-1:0];
    logic [PTR_W-1:0]        rr_ptr;

    logic                    cand_found;
    logic [PTR_W-1:0]        cand_ch;
    logic [PTR_W-1:0]        probe;
    logic [PTR_W-1:0]        rr_ptr_nxt;
    logic                    pool_hit;
    logic [IDX_W-1:0]        fill_idx;
    logic                    fill_en;
    logic [DB_ENTRY_NUM-1:0] fill_mask;
    logic [DB_ENTRY_NUM-1:0] rel_mask;
    logic [DB_ENTRY_NUM-1:0] free_after_fill;
    logic [DB_ENTRY_NUM-1:0] new_bits;
    logic [CNT_W-1:0]        rel_cnt;

    assign alloc_vld = slot_vld;
    assign alloc_idx = slot_idx;

    // Refill candidate: first slot from rr_ptr (with wrap) that is empty or being consumed.
    always_comb begin
        cand_found = 1'b0;
        cand_ch    = '0;
        probe      = '0;
        for (int unsigned k = 0; k < CH_NUM; k++) begin
            probe = PTR_W'((32'(rr_ptr) + k) % CH_NUM);
            if (!cand_found && (!slot_vld[probe] || alloc_rdy[probe])) begin
                cand_found = 1'b1;
                cand_ch    = probe;
            end
        end
        rr_ptr_nxt = (32'(cand_ch) == CH_NUM - 1) ? '0 : cand_ch + PTR_W'(1);
    end

    // Lowest free entry in the registered bitmap.
    always_comb begin
        pool_hit = 1'b0;
        fill_idx = '0;
        for (int unsigned j = 0; j < DB_ENTRY_NUM; j++) begin
            if (free_vec[j] && !pool_hit) begin
                pool_hit = 1'b1;
                fill_idx = IDX_W'(j);
            end
        end
    end

    assign fill_en   = cand_found && pool_hit;
    assign fill_mask = fill_en ? (DB_ENTRY_NUM'(1) << fill_idx) : '0;

    // Release bitmap; the counter only credits bits that actually become set,
    // so illegal double/duplicate releases keep free_cnt equal to popcount(free_vec).
    always_comb begin
        rel_mask = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (rel_vld[i]) begin
                rel_mask[rel_idx[i]] = 1'b1;
            end
        end
        free_after_fill = free_vec & ~fill_mask;
        new_bits        = rel_mask & ~free_after_fill;
        rel_cnt         = '0;
        for (int unsigned j = 0; j < DB_ENTRY_NUM; j++) begin
            rel_cnt = rel_cnt + CNT_W'(new_bits[j]);
        end
    end

    // Pool, counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_vec <= '1;
            free_cnt <= CNT_W'(DB_ENTRY_NUM);
            rr_ptr   <= '0;
        end else begin
            free_vec <= free_after_fill | rel_mask;
            free_cnt <= free_cnt - CNT_W'(fill_en) + rel_cnt;
            if (fill_en) begin
                rr_ptr <= rr_ptr_nxt;
            end
        end
    end

    // Per-channel slots: refill wins over clear so a consumed slot can reload back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= '0;
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                slot_idx[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                if (fill_en && (cand_ch == PTR_W'(i))) begin
                    slot_vld[i] <= 1'b1;
                    slot_idx[i] <= fill_idx;
                end else if (slot_vld[i] && alloc_rdy[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
        end
    end

`ifdef WDB_ALLOC_CHK_EN
    logic [CH_NUM-1:0] err_ch_c;

    // Per-channel illegal release detection against pre-update state.
    always_comb begin
        err_ch_c = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (rel_vld[i]) begin
                if (free_vec[rel_idx[i]]) begin
                    err_ch_c[i] = 1'b1;
                end
                for (int unsigned j = 0; j < i; j++) begin
                    if (rel_vld[j] && (rel_idx[j] == rel_idx[i])) begin
                        err_ch_c[i] = 1'b1;
                    end
                end
                for (int unsigned s = 0; s < CH_NUM; s++) begin
                    if (slot_vld[s] && (slot_idx[s] == rel_idx[i])) begin
                        err_ch_c[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_err <= 1'b0;
        end else if (|err_ch_c) begin
            alloc_err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                if (err_ch_c[i]) begin
                    $error("wdb_entry_alloc: illegal release ch %0d idx %0d", i, rel_idx[i]);
                end
            end
        end
    end
`endif
`else
    assign alloc_err = 1'b0;
`endif

endmodule

// File: tb/tb_wdb_entry_alloc.sv
module tb_wdb_entry_alloc;

    logic       clk;
    logic       rst_n;
    logic [3:0] alloc_vld;
    logic [5:0] alloc_idx [3:0];
    logic [3:0] alloc_rdy;
    logic [3:0] rel_vld;
    logic [5:0] rel_idx   [3:0];
    logic [6:0] free_cnt;
    logic       alloc_err;

    int n_checks;
    int n_errors;

    // Reference model: free set, slot contents, rr pointer, outstanding indexes.
    bit         m_free [64];
    bit [3:0]   m_vld;
    int         m_idx  [4];
    int         m_rr;
    int         m_cnt;
    int         outst  [$];

    wdb_entry_alloc #(.CH_NUM(4), .DB_ENTRY_NUM(64), .IDX_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc_vld (alloc_vld),
        .alloc_idx (alloc_idx),
        .alloc_rdy (alloc_rdy),
        .rel_vld   (rel_vld),
        .rel_idx   (rel_idx),
        .free_cnt  (free_cnt),
        .alloc_err (alloc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int e = 0; e < 64; e++) m_free[e] = 1'b1;
        m_vld = '0;
        for (int i = 0; i < 4; i++) m_idx[i] = 0;
        m_rr  = 0;
        m_cnt = 64;
        outst.delete();
    endtask

    // One clock of the allocation rules, using the inputs currently driven.
    task automatic model_step();
        int low;
        int cand;
        int c;
        low  = -1;
        cand = -1;
        for (int e = 0; e < 64; e++) if (m_free[e] && low < 0) low = e;
        for (int k = 0; k < 4; k++) begin
            c = (m_rr + k) % 4;
            if (cand < 0 && (!m_vld[c] || alloc_rdy[c])) cand = c;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_vld[i] && alloc_rdy[i]) begin
                outst.push_back(m_idx[i]);
                m_vld[i] = 1'b0;
            end
        end
        if (cand >= 0 && low >= 0) begin
            m_vld[cand] = 1'b1;
            m_idx[cand] = low;
            m_free[low] = 1'b0;
            m_cnt       = m_cnt - 1;
            m_rr        = (cand + 1) % 4;
        end
        for (int i = 0; i < 4; i++) begin
            if (rel_vld[i] && !m_free[rel_idx[i]]) begin
                m_free[rel_idx[i]] = 1'b1;
                m_cnt              = m_cnt + 1;
            end
        end
    endtask

    task automatic remove_outst(input int v);
        for (int p = 0; p < outst.size(); p++) begin
            if (outst[p] == v) begin
                outst.delete(p);
                break;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive_cycle(input logic [3:0] r, input logic [3:0] rv,
                               input int i0, input int i1, input int i2, input int i3);
        alloc_rdy  = r;
        rel_vld    = rv;
        rel_idx[0] = 6'(i0);
        rel_idx[1] = 6'(i1);
        rel_idx[2] = 6'(i2);
        rel_idx[3] = 6'(i3);
        model_step();
        @(posedge clk);
        @(negedge clk);
        alloc_rdy = '0;
        rel_vld   = '0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        alloc_rdy = '0;
        rel_vld   = '0;
        for (int i = 0; i < 4; i++) rel_idx[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (alloc_vld !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_vld got %b want 0000", alloc_vld);
        end
        n_checks++;
        if (free_cnt !== 7'd64) begin
            n_errors++;
            $display("FAIL reset_free_cnt got %0d want 64", free_cnt);
        end
        n_checks++;
        if (alloc_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_err got %b want 0", alloc_err);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (alloc_idx[i] !== 6'd0) begin
                n_errors++;
                $display("FAIL reset_idx ch %0d got %0d want 0", i, alloc_idx[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill_order();
        logic [3:0] exp_vld;
        for (int c = 1; c <= 4; c++) begin
            drive_cycle(4'b0000, 4'b0000, 0, 0, 0, 0);
            exp_vld = 4'((1 << c) - 1);
            n_checks++;
            if (alloc_vld !== exp_vld || alloc_idx[c-1] !== 6'(c - 1) || free_cnt !== 7'(64 - c)) begin
                n_errors++;
                $display("FAIL fill_order cycle %0d got vld %b idx %0d cnt %0d want vld %b idx %0d cnt %0d",
                         c, alloc_vld, alloc_idx[c-1], free_cnt, exp_vld, c - 1, 64 - c);
            end
        end
    endtask

    task automatic test_drain();
        bit seen [64];
        int taken;
        int dups;
        bit done;
        taken = 0;
        dups  = 0;
        done  = 1'b0;
        for (int e = 0; e < 64; e++) seen[e] = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (alloc_vld[i]) begin
                    if (seen[alloc_idx[i]]) dups++;
                    seen[alloc_idx[i]] = 1'b1;
                    taken++;
                end
            end
            drive_cycle(4'b1111, 4'b0000, 0, 0, 0, 0);
            n_checks++;
            if (alloc_vld !== m_vld || free_cnt !== 7'(m_cnt)) begin
                n_errors++;
                $display("FAIL drain_model cyc %0d got vld %b cnt %0d want vld %b cnt %0d",
                         cyc, alloc_vld, free_cnt, m_vld, m_cnt);
            end
            if (alloc_vld == 4'b0000 && free_cnt == 7'd0) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL drain_timeout got vld %b cnt %0d want vld 0000 cnt 0", alloc_vld, free_cnt);
        end
        n_checks++;
        if (taken != 64 || dups != 0) begin
            n_errors++;
            $display("FAIL drain_unique got taken %0d dups %0d want taken 64 dups 0", taken, dups);
        end
    endtask

    task automatic test_release_empty();
        drive_cycle(4'b0000, 4'b0100, 0, 0, 17, 0);
        remove_outst(17);
        n_checks++;
        if (free_cnt !== 7'd1 || alloc_vld !== 4'b0000) begin
            n_errors++;
            $display("FAIL rel_empty_c1 got cnt %0d vld %b want cnt 1 vld 0000", free_cnt, alloc_vld);
        end
        drive_cycle(4'b0000, 4'b0000, 0, 0, 0, 0);
        n_checks++;
        if (alloc_vld !== 4'b0001 || alloc_idx[0] !== 6'd17 || free_cnt !== 7'd0) begin
            n_errors++;
            $display("FAIL rel_empty_c2 got vld %b idx %0d cnt %0d want vld 0001 idx 17 cnt 0",
                     alloc_vld, alloc_idx[0], free_cnt);
        end
    endtask

    task automatic test_multi_release();
        drive_cycle(4'b0000, 4'b1111, 40, 9, 33, 21);
        remove_outst(40); remove_outst(9); remove_outst(33); remove_outst(21);
        n_checks++;
        if (free_cnt !== 7'd4) begin
            n_errors++;
            $display("FAIL multi_rel_cnt got %0d want 4", free_cnt);
        end
        repeat (3) drive_cycle(4'b0000, 4'b0000, 0, 0, 0, 0);
        n_checks++;
        if (alloc_vld !== 4'b1111 || alloc_idx[1] !== 6'd9 || alloc_idx[2] !== 6'd21 ||
            alloc_idx[3] !== 6'd33 || free_cnt !== 7'd1) begin
            n_errors++;
            $display("FAIL multi_rel_fill got vld %b idx %0d %0d %0d cnt %0d want vld 1111 idx 9 21 33 cnt 1",
                     alloc_vld, alloc_idx[1], alloc_idx[2], alloc_idx[3], free_cnt);
        end
        // Slot 0 handshakes while four channels release; refill uses the pre-release pool.
        drive_cycle(4'b0001, 4'b1111, 50, 2, 60, 11);
        remove_outst(50); remove_outst(2); remove_outst(60); remove_outst(11);
        n_checks++;
        if (alloc_vld !== 4'b1111 || alloc_idx[0] !== 6'd40 || free_cnt !== 7'd4) begin
            n_errors++;
            $display("FAIL multi_rel_hs got vld %b idx0 %0d cnt %0d want vld 1111 idx0 40 cnt 4",
                     alloc_vld, alloc_idx[0], free_cnt);
        end
        drive_cycle(4'b0001, 4'b0000, 0, 0, 0, 0);
        n_checks++;
        if (alloc_vld !== 4'b1111 || alloc_idx[0] !== 6'd2 || free_cnt !== 7'd3) begin
            n_errors++;
            $display("FAIL multi_rel_b2b got vld %b idx0 %0d cnt %0d want vld 1111 idx0 2 cnt 3",
                     alloc_vld, alloc_idx[0], free_cnt);
        end
    endtask

    task automatic test_random();
        int ri [4];
        logic [3:0] rv;
        int p;
        int bad;
        bad = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rv = '0;
            for (int ch = 0; ch < 4; ch++) begin
                ri[ch] = $urandom_range(0, 63);
                if ($urandom_range(0, 3) == 0 && outst.size() > 0) begin
                    p      = $urandom_range(0, outst.size() - 1);
                    ri[ch] = outst[p];
                    rv[ch] = 1'b1;
                    outst.delete(p);
                end
            end
            drive_cycle(4'($urandom_range(0, 15)), rv, ri[0], ri[1], ri[2], ri[3]);
            n_checks++;
            if (alloc_vld !== m_vld || free_cnt !== 7'(m_cnt)) begin
                n_errors++;
                $display("FAIL rand_state cyc %0d got vld %b cnt %0d want vld %b cnt %0d",
                         cyc, alloc_vld, free_cnt, m_vld, m_cnt);
            end
            for (int i = 0; i < 4; i++) begin
                if (m_vld[i]) begin
                    n_checks++;
                    if (alloc_idx[i] !== 6'(m_idx[i])) begin
                        n_errors++;
                        $display("FAIL rand_idx cyc %0d ch %0d got %0d want %0d", cyc, i, alloc_idx[i], m_idx[i]);
                    end
                end
            end
            n_checks++;
            if (int'(free_cnt) + $countones(alloc_vld) + outst.size() != 64) begin
                n_errors++;
                $display("FAIL rand_conserve cyc %0d got %0d want 64", cyc,
                         int'(free_cnt) + $countones(alloc_vld) + outst.size());
            end
            if (alloc_err !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL rand_err got %0d cycles with alloc_err want 0", bad);
        end
    endtask

    task automatic test_async_reset();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (34) drive_cycle(4'b1111, 4'b0000, 0, 0, 0, 0);
        n_checks++;
        if (free_cnt !== 7'(m_cnt) || free_cnt > 7'd32) begin
            n_errors++;
            $display("FAIL async_pre got cnt %0d want %0d (<=32)", free_cnt, m_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (alloc_vld !== 4'b0000 || free_cnt !== 7'd64) begin
            n_errors++;
            $display("FAIL async_now got vld %b cnt %0d want vld 0000 cnt 64", alloc_vld, free_cnt);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(4'b0000, 4'b0000, 0, 0, 0, 0);
        n_checks++;
        if (alloc_vld !== 4'b0001 || alloc_idx[0] !== 6'd0 || free_cnt !== 7'd63) begin
            n_errors++;
            $display("FAIL async_refill got vld %b idx %0d cnt %0d want vld 0001 idx 0 cnt 63",
                     alloc_vld, alloc_idx[0], free_cnt);
        end
    endtask

`ifdef WDB_ALLOC_CHK_EN
    task automatic test_chk();
        drive_cycle(4'b0000, 4'b0001, 5, 0, 0, 0);
        n_checks++;
        if (alloc_err !== 1'b1 || free_cnt !== 7'(m_cnt)) begin
            n_errors++;
            $display("FAIL chk_set got err %b cnt %0d want err 1 cnt %0d", alloc_err, free_cnt, m_cnt);
        end
        repeat (3) drive_cycle(4'b0000, 4'b0000, 0, 0, 0, 0);
        n_checks++;
        if (alloc_err !== 1'b1) begin
            n_errors++;
            $display("FAIL chk_sticky got %b want 1", alloc_err);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_fill_order();
        test_drain();
        test_release_empty();
        test_multi_release();
        test_random();
        test_async_reset();
`ifdef WDB_ALLOC_CHK_EN
        test_chk();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
